// File: rtl/pipe_pkg.sv
// Shared defaults and counter helpers for the pipeline stage chain.
package pipe_pkg;

  localparam int unsigned DW_DEF     = 32;
  localparam int unsigned NSTAGE_DEF = 4;
  localparam int unsigned CNT_W      = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake, payload, per-stage control and statistics bundle of the stage chain.
interface pipe_stage_chain_if #(
  parameter int unsigned DW     = pipe_pkg::DW_DEF,
  parameter int unsigned NSTAGE = pipe_pkg::NSTAGE_DEF
);

  logic                       in_valid;
  logic [DW-1:0]              in_data;
  logic                       in_allowin;
  logic [NSTAGE-1:0]          ready_go;
  logic [NSTAGE-1:0]          flush;
  logic                       out_ready;
  logic                       out_valid;
  logic [DW-1:0]              out_data;
  logic [NSTAGE-1:0]          stage_valid;
  logic [NSTAGE*DW-1:0]       stage_data;
  logic [pipe_pkg::CNT_W-1:0] stall_cnt;
  logic [pipe_pkg::CNT_W-1:0] bubble_cnt;

  // Environment side: offers payloads, controls stages, consumes output.
  modport master (
    output in_valid, in_data, ready_go, flush, out_ready,
    input  in_allowin, out_valid, out_data, stage_valid, stage_data,
           stall_cnt, bubble_cnt
  );

  // Chain side.
  modport slave (
    input  in_valid, in_data, ready_go, flush, out_ready,
    output in_allowin, out_valid, out_data, stage_valid, stage_data,
           stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: valid/data register plus its go/allowin handshake terms.
module pipe_stage #(
  parameter int unsigned DW = pipe_pkg::DW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          ready_go,
  input  logic          flush,
  input  logic          down_allowin,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          go_c,
  output logic          allowin_c
);

  // A flushed stage never forwards and always opens for the next payload.
  assign go_c      = valid & ready_go & ~flush;
  assign allowin_c = ~valid | flush | (ready_go & down_allowin);

  // Load on allowin (flush kills the incoming payload); otherwise hold.
  // Flush forces allowin, so the "clear on flush" case is covered by the load path.
  always_ff @(posedge clk) begin
    if (resetn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (allowin_c) begin
      valid <= up_valid & ~flush;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of NSTAGE handshaked pipeline stages with flush, backpressure and
// stall/bubble statistics. resetn is synchronous and active-high.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned NSTAGE = NSTAGE_DEF
) (
  input logic               clk,
  input logic               resetn,
  pipe_stage_chain_if.slave bus
);

  logic in_allowin;
  logic out_valid;
  cnt_t stall_cnt;
  cnt_t bubble_cnt;

  // Per-stage scopes keep the allowin ripple in separate nets (no self-looped vector).
  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          down_allow;
    logic          valid;
    logic [DW-1:0] data;
    logic          go;
    logic          allow;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = g_stage[i-1].go;
      assign up_data  = g_stage[i-1].data;
    end

    if (i == NSTAGE - 1) begin : g_tail
      assign down_allow = bus.out_ready;
    end else begin : g_mid
      assign down_allow = g_stage[i+1].allow;
    end

    pipe_stage #(.DW(DW)) u_stage (
      .clk          (clk),
      .resetn       (resetn),
      .up_valid     (up_valid),
      .up_data      (up_data),
      .ready_go     (bus.ready_go[i]),
      .flush        (bus.flush[i]),
      .down_allowin (down_allow),
      .valid        (valid),
      .data         (data),
      .go_c         (go),
      .allowin_c    (allow)
    );

    assign bus.stage_valid[i]           = valid;
    assign bus.stage_data[i*DW +: DW]   = data;
  end

  assign in_allowin     = g_stage[0].allow;
  assign out_valid      = g_stage[NSTAGE-1].go;
  assign bus.in_allowin = in_allowin;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = g_stage[NSTAGE-1].data;

  // Saturating statistics: refused offers and cycles with nothing leaving.
  always_ff @(posedge clk) begin
    if (resetn) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.in_valid && !in_allowin) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (!out_valid) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end

  assign bus.stall_cnt  = stall_cnt;
  assign bus.bubble_cnt = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (NSTAGE=4, DW=32) with an output scoreboard.
module tb_pipe_stage_chain;

  logic clk;
  logic resetn;

  pipe_stage_chain_if #(.DW(32), .NSTAGE(4)) bus ();

  pipe_stage_chain #(.DW(32), .NSTAGE(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int          compared   = 0;
  int          mismatched = 0;
  int          popped     = 0;
  bit          mon_en     = 1'b0;
  logic [31:0] sb [$];
  logic [31:0] exp_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: every transfer must match the oldest expected payload.
  always @(negedge clk) begin
    if (mon_en && resetn === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: got %0h expected no output", bus.out_data);
      end else begin
        exp_v = sb.pop_front();
        popped++;
        if (bus.out_data !== exp_v) begin
          mismatched++;
          $display("FAIL sb_order: got %0h expected %0h", bus.out_data, exp_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ready_go  = '1;
    bus.flush     = '0;
    bus.out_ready = 1'b1;
    resetn = 1'b1;
    step();
    step();
    resetn = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ready_go  = '1;
    bus.flush     = '0;
    bus.out_ready = 1'b1;
    resetn = 1'b1;
    step();
    step();
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    compared++;
    if (bus.stage_valid !== 4'b0000) begin
      mismatched++; $display("FAIL reset_stage_valid: got %b expected 0000", bus.stage_valid);
    end
    compared++;
    if (bus.in_allowin !== 1'b1) begin
      mismatched++; $display("FAIL reset_in_allowin: got %b expected 1", bus.in_allowin);
    end
    compared++;
    if (bus.stall_cnt !== 32'd0) begin
      mismatched++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
    compared++;
    if (bus.bubble_cnt !== 32'd0) begin
      mismatched++; $display("FAIL reset_bubble_cnt: got %0d expected 0", bus.bubble_cnt);
    end
    resetn = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_streaming();
    int p0;
    do_reset();
    p0 = popped;
    for (int c = 0; c < 14; c++) begin
      bus.in_valid = (c < 8);
      bus.in_data  = 32'(c + 1);
      @(negedge clk);
      if (c <= 12) begin
        compared++;
        if (bus.bubble_cnt !== 32'((c < 4) ? c : 4)) begin
          mismatched++;
          $display("FAIL stream_bubble_cnt c=%0d: got %0d expected %0d", c, bus.bubble_cnt, (c < 4) ? c : 4);
        end
      end
      compared++;
      if (bus.out_valid !== ((c >= 4 && c < 12) ? 1'b1 : 1'b0)) begin
        mismatched++; $display("FAIL stream_out_valid c=%0d: got %b", c, bus.out_valid);
      end
      if (c >= 4 && c < 12) begin
        compared++;
        if (bus.out_data !== 32'(c - 3)) begin
          mismatched++;
          $display("FAIL stream_out_data c=%0d: got %0d expected %0d", c, bus.out_data, c - 3);
        end
      end
      if (bus.in_valid && bus.in_allowin) sb.push_back(bus.in_data);
      step();
    end
    bus.in_valid = 1'b0;
    compared++;
    if (popped - p0 != 8) begin
      mismatched++; $display("FAIL stream_count: got %0d expected 8", popped - p0);
    end
    compared++;
    if (bus.stall_cnt !== 32'd0) begin
      mismatched++; $display("FAIL stream_stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int p0;
    do_reset();
    p0 = popped;
    for (int c = 0; c < 16; c++) begin
      bus.out_ready = (c >= 6);
      bus.in_valid  = (sent < 6);
      bus.in_data   = 32'(sent + 1);
      @(negedge clk);
      if (c == 3) begin
        compared++;
        if (bus.in_allowin !== 1'b1) begin
          mismatched++; $display("FAIL bp_allowin_open: got %b expected 1", bus.in_allowin);
        end
      end
      if (c == 4 || c == 5) begin
        compared++;
        if (bus.in_allowin !== 1'b0) begin
          mismatched++; $display("FAIL bp_allowin_full c=%0d: got %b expected 0", c, bus.in_allowin);
        end
        compared++;
        if (bus.stage_valid !== 4'b1111) begin
          mismatched++; $display("FAIL bp_stage_valid c=%0d: got %b expected 1111", c, bus.stage_valid);
        end
      end
      if (c == 6) begin
        compared++;
        if (bus.stall_cnt !== 32'd2) begin
          mismatched++; $display("FAIL bp_stall_cnt: got %0d expected 2", bus.stall_cnt);
        end
      end
      if (bus.in_valid && bus.in_allowin) begin
        sb.push_back(bus.in_data);
        sent++;
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    compared++;
    if (popped - p0 != 6 || sb.size() != 0) begin
      mismatched++; $display("FAIL bp_count: got %0d expected 6 (left %0d)", popped - p0, sb.size());
    end
    compared++;
    if (bus.stall_cnt !== 32'd2) begin
      mismatched++; $display("FAIL bp_stall_final: got %0d expected 2", bus.stall_cnt);
    end
  endtask

  task automatic test_mid_stall();
    int exp_b [11] = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7, 7};
    int p0;
    do_reset();
    p0 = popped;
    for (int c = 0; c < 13; c++) begin
      bus.in_valid = (c < 4);
      bus.in_data  = 32'(11 + c);
      bus.ready_go = (c >= 4 && c <= 6) ? 4'b1101 : 4'b1111;
      @(negedge clk);
      if (c <= 10) begin
        compared++;
        if (bus.bubble_cnt !== 32'(exp_b[c])) begin
          mismatched++;
          $display("FAIL stall_bubble_cnt c=%0d: got %0d expected %0d", c, bus.bubble_cnt, exp_b[c]);
        end
      end
      if (c == 5) begin
        compared++;
        if (bus.stage_valid !== 4'b1011) begin
          mismatched++; $display("FAIL stall_stage_valid5: got %b expected 1011", bus.stage_valid);
        end
        compared++;
        if (bus.stage_data[31:0] !== 32'd14 || bus.stage_data[63:32] !== 32'd13) begin
          mismatched++;
          $display("FAIL stall_hold_data: got %0d/%0d expected 14/13", bus.stage_data[31:0], bus.stage_data[63:32]);
        end
      end
      if (c == 6) begin
        compared++;
        if (bus.stage_valid !== 4'b0011) begin
          mismatched++; $display("FAIL stall_stage_valid6: got %b expected 0011", bus.stage_valid);
        end
      end
      if (bus.in_valid && bus.in_allowin) sb.push_back(bus.in_data);
      step();
    end
    bus.in_valid = 1'b0;
    bus.ready_go = '1;
    compared++;
    if (popped - p0 != 4 || sb.size() != 0) begin
      mismatched++; $display("FAIL stall_count: got %0d expected 4 (left %0d)", popped - p0, sb.size());
    end
  endtask

  task automatic test_flush();
    int p0;
    do_reset();
    p0 = popped;
    for (int c = 0; c < 13; c++) begin
      bus.in_valid = (c < 6);
      bus.in_data  = 32'hA0 + 32'(c);
      bus.flush    = (c == 4) ? 4'b0011 : ((c == 5) ? 4'b0100 : 4'b0000);
      @(negedge clk);
      if (c == 4) begin
        compared++;
        if (bus.in_allowin !== 1'b1) begin
          mismatched++; $display("FAIL flush_allowin: got %b expected 1", bus.in_allowin);
        end
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA0) begin
          mismatched++; $display("FAIL flush_head: got %b/%0h expected 1/a0", bus.out_valid, bus.out_data);
        end
      end
      if (c == 5) begin
        compared++;
        if (bus.stage_valid !== 4'b1000) begin
          mismatched++; $display("FAIL flush_stage_valid5: got %b expected 1000", bus.stage_valid);
        end
      end
      if (c == 6) begin
        compared++;
        if (bus.stage_valid !== 4'b0001) begin
          mismatched++; $display("FAIL flush_stage_valid6: got %b expected 0001", bus.stage_valid);
        end
      end
      if (c == 9) begin
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5) begin
          mismatched++; $display("FAIL flush_f_out: got %b/%0h expected 1/a5", bus.out_valid, bus.out_data);
        end
      end
      if ((c == 0 || c == 1 || c == 5) && bus.in_allowin) sb.push_back(bus.in_data);
      step();
    end
    bus.in_valid = 1'b0;
    bus.flush    = '0;
    compared++;
    if (popped - p0 != 3 || sb.size() != 0) begin
      mismatched++; $display("FAIL flush_count: got %0d expected 3 (left %0d)", popped - p0, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    p0 = popped;
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = (c >= 5);
      bus.in_valid  = (c < 4) || (c == 5);
      bus.in_data   = (c < 4) ? 32'(21 + c) : 32'h55;
      resetn        = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        compared++;
        if (bus.stage_valid !== 4'b1111) begin
          mismatched++; $display("FAIL rmid_full: got %b expected 1111", bus.stage_valid);
        end
      end
      if (c == 5) begin
        compared++;
        if (bus.stage_valid !== 4'b0000 || bus.out_valid !== 1'b0) begin
          mismatched++; $display("FAIL rmid_cleared: got %b/%b expected 0000/0", bus.stage_valid, bus.out_valid);
        end
        compared++;
        if (bus.in_allowin !== 1'b1) begin
          mismatched++; $display("FAIL rmid_allowin: got %b expected 1", bus.in_allowin);
        end
        compared++;
        if (bus.stall_cnt !== 32'd0 || bus.bubble_cnt !== 32'd0) begin
          mismatched++; $display("FAIL rmid_counters: got %0d/%0d expected 0/0", bus.stall_cnt, bus.bubble_cnt);
        end
        if (bus.in_allowin) sb.push_back(bus.in_data);
      end
      if (c == 8) begin
        compared++;
        if (bus.out_valid !== 1'b0) begin
          mismatched++; $display("FAIL rmid_early: got %b expected 0", bus.out_valid);
        end
      end
      if (c == 9) begin
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55) begin
          mismatched++; $display("FAIL rmid_latency: got %b/%0h expected 1/55", bus.out_valid, bus.out_data);
        end
      end
      step();
    end
    bus.in_valid = 1'b0;
    compared++;
    if (popped - p0 != 1 || sb.size() != 0) begin
      mismatched++; $display("FAIL rmid_count: got %0d expected 1 (left %0d)", popped - p0, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mid_stall();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter DW, default 32: payload width per stage in bits.
REQ-002 SHALL have parameter NSTAGE, default 4: number of stages, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous and active-high despite its name.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream offers a payload.
REQ-006 SHALL have port in_data, input, DW bits: upstream payload.
REQ-007 SHALL have port in_allowin, output, 1 bit: stage 0 accepts this cycle.
REQ-008 SHALL have port ready_go, input, NSTAGE bits: bit i set means stage i's work is complete.
REQ-009 SHALL have port flush, input, NSTAGE bits: bit i kills stage i this cycle.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-011 SHALL have port out_valid, output, 1 bit: last stage holds a payload ready to leave.
REQ-012 SHALL have port out_data, output, DW bits: last-stage payload.
REQ-013 SHALL have port stage_valid, output, NSTAGE bits: per-stage valid, for hazard detection.
REQ-014 SHALL have port stage_data, output, NSTAGE*DW bits: stage i payload at bits [i*DW +: DW].
REQ-015 SHALL have port stall_cnt, output, 32 bits: count of cycles with in_valid=1 and in_allowin=0.
REQ-016 SHALL have port bubble_cnt, output, 32 bits: count of cycles with out_valid=0.

Function
REQ-017 SHALL compute go[i] = v[i] & ready_go[i] & ~flush[i].
REQ-018 SHALL compute allowin[i] = ~v[i] | flush[i] | (ready_go[i] & allowin[i+1]).
REQ-019 SHALL use out_ready as allowin[NSTAGE]; in_allowin SHALL equal allowin[0].
REQ-020 SHALL set out_valid = go[NSTAGE-1] and out_data = d[NSTAGE-1].
REQ-021 SHALL, for the incoming valid into stage i, use in_valid for stage 0 and go[i-1] otherwise.
REQ-022 SHALL, when allowin[i] is set, load v[i] with (incoming valid & ~flush[i]).
REQ-023 SHALL, when allowin[i] is set and the incoming valid is set, load d[i] from the upstream payload.
REQ-024 SHALL otherwise hold d[i], and hold v[i] unless flush[i] is set, in which case v[i] SHALL be cleared.
REQ-025 SHALL have a latency of NSTAGE-1 edges: a payload accepted at edge k is on out_data after edge k+NSTAGE-1.
REQ-026 SHALL sustain a throughput of 1 per cycle when all ready_go bits and out_ready are 1.
REQ-027 SHALL never lose, duplicate or reorder payloads under backpressure; with all stages full and out_ready=0, in_allowin SHALL be 0.
REQ-028 SHALL, when a transfer and a flush hit the same stage, let the flush win: the payload entering that stage is discarded.
REQ-029 SHALL treat a flush bit on an empty stage as a no-op.
REQ-030 SHALL make stall_cnt and bubble_cnt saturate at 32'hFFFF_FFFF and never wrap.

Reset
REQ-031 SHALL, while resetn=1 at a clock edge, clear all v[i], d[i], stall_cnt and bubble_cnt to 0.
REQ-032 SHALL, during reset, drive out_valid=0 and in_allowin=1 (combinational from cleared state).
REQ-033 SHALL discard all in-flight payloads when reset is asserted mid-operation; the first payload after release enters with latency per REQ-025.

Structure
REQ-034 SHALL place default DW/NSTAGE values and the counter width (32) in shared package pipe_pkg.
REQ-035 SHALL implement one stage (valid/data register plus the allowin/go logic) as sub-module pipe_stage, instantiated NSTAGE times via generate.

Verification (NSTAGE=4, DW=32)
REQ-036 SHALL check reset: assert resetn for 2 cycles -> out_valid=0, stage_valid=4'b0000, in_allowin=1, both counters 0.
REQ-037 SHALL check streaming: in_data 1,2,3,... every cycle, all go, out_ready=1 -> value 1 on out_data 3 edges after acceptance, then one value per cycle, bubble_cnt stops incrementing.
REQ-038 SHALL check backpressure: out_ready=0 for 6 cycles while feeding 1..6 -> in_allowin=0 after 4 accepts, stall_cnt=2, release yields 1,2,3,4,5,6 in order.
REQ-039 SHALL check a mid-chain stall: ready_go=4'b1101 for 3 cycles with the pipe full -> stages 0-1 hold, stages 2-3 drain, bubble_cnt increments by 1 per empty-output cycle, no data loss.
REQ-040 SHALL check flush: pipe holds A(s3),B(s2),C(s1),D(s0); flush=4'b0011 with in_valid=1 (E) -> output sequence A,B,F..., C/D/E never appear.
REQ-041 SHALL check reset mid-stream: assert resetn with 4 valid stages -> all stage_valid=0 next cycle, the next input emerges after 3 edges.
